debounce_sync: RTL and testbench

Input conditioning stage that sits directly upstream of the team's D flip-flop data-capture register. It takes a raw, asynchronous, possibly bouncing level (switch, button, external pin), synchronizes it into the `clk` domain, and accepts a new level only after it has been stable for a programmable number of cycles. It drives a clean registered level with its complement (`q`/`qb`, matching the flip-flop pair it feeds), plus one-cycle rise/fall pulses for downstream edge-triggered logic.

---
 rtl/debounce_sync.sv | 134 +++++++++++++
 tb/tb_debounce_sync.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debounce_sync                                                |
// | Description : Synchronizes a raw asynchronous level into the clk domain   |
// |               and accepts a new level only after it has persisted for     |
// |               STABLE_CNT consecutive cycles. Drives a registered level    |
// |               with its complement plus one-cycle rise/fall pulses.        |
// | Ports       : clk   - single clock, rising edge                           |
// |               rst   - asynchronous reset, active low                      |
// |               d_in  - raw asynchronous level                              |
// |               q/qb  - debounced level and its registered complement       |
// |               rise  - one-cycle pulse when q loads 1                      |
// |               fall  - one-cycle pulse when q loads 0                      |
// |               busy  - high while a candidate change is being qualified    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module debounce_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int STABLE_CNT  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic q,
   output logic qb,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   // Terminal count: the STABLE_CNT-th mismatching sample is seen while
   // the counter holds STABLE_CNT-1.
   localparam logic [CNT_W-1:0] c_cnt_term = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_q;
   logic                   r_qb;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_q_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;

   // Plain shift chain: nothing may sit between stages so that a
   // metastable first stage gets a full period to resolve.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_qb    <= 1'b1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_q     <= w_q_nxt;
         r_qb    <= ~w_q_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_q_nxt     = r_q;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_s != r_q) begin
               w_state_nxt = ST_COUNT;
               w_cnt_nxt   = c_cnt_one;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         ST_COUNT: begin
            // The bounce test comes first, so a sample that reverts on
            // the terminal edge still abandons the attempt.
            if (w_s == r_q) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_cnt_term) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_q_nxt     = w_s;
               // w_s differs from q here, so its value names the edge.
               w_rise_nxt  = w_s;
               w_fall_nxt  = ~w_s;
            end else begin
               w_cnt_nxt   = r_cnt + c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign q    = r_q;
   assign qb   = r_qb;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = (r_state == ST_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debounce_sync                                             |
// | Description : Self-checking bench for debounce_sync: directed latency,    |
// |               bounce, reset and glitch sequences, a vector table, and a   |
// |               randomized run against a run-length reference model.       |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_debounce_sync;

   localparam int SS = 2;
   localparam int CW = 4;
   localparam int SC = 10;

   logic clk = 1'b0;
   logic rst;
   logic d_in;
   logic q, qb, rise, fall, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_rise   = 0;
   int n_fall   = 0;

   // Reference model: the synchronizer is a pure delay of SS edges, and
   // q flips once the delayed input has disagreed with q at SC edges in a row.
   logic m_q;
   int   m_run;
   logic m_rise;
   logic m_fall;
   logic dq[$];

   typedef struct {
      logic d;
      int   cycles;
      logic exp_q;
      int   exp_rise;
      int   exp_fall;
   } vec_t;

   vec_t vecs[7];

   debounce_sync #(
      .SYNC_STAGES (SS),
      .CNT_W       (CW),
      .STABLE_CNT  (SC)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .d_in (d_in),
      .q    (q),
      .qb   (qb),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {q, qb, rise, fall, busy};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: {q,qb,rise,fall,busy} got %b want %b at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q    = 1'b0;
      m_run  = 0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      dq.delete();
   endtask

   task automatic model_edge(input logic d);
      logic s;
      s = (dq.size() >= SS) ? dq[dq.size() - SS] : 1'b0;
      dq.push_back(d);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_q) begin
         m_run++;
         if (m_run == SC) begin
            m_q    = s;
            m_rise = s;
            m_fall = ~s;
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
   endtask

   // Called at a falling edge; drives d, takes one rising edge, checks
   // against the model, and returns at the next falling edge.
   task automatic step(input logic d);
      d_in = d;
      @(posedge clk);
      model_edge(d);
      #1;
      if (rise === 1'b1) n_rise++;
      if (fall === 1'b1) n_fall++;
      chk("model", {m_q, ~m_q, m_rise, m_fall, (m_run != 0)});
      @(negedge clk);
   endtask

   // Called at a falling edge; asserts reset between edges and checks that
   // it takes effect before any clock edge arrives.
   task automatic apply_reset(input int cycles, input logic toggle);
      rst = 1'b0;
      #1;
      model_reset();
      chk("reset_async", 5'b01000);
      for (int i = 0; i < cycles; i++) begin
         if (toggle) d_in = ~d_in;
         @(posedge clk);
         #1;
         chk("reset_hold", 5'b01000);
         @(negedge clk);
      end
      rst = 1'b1;
   endtask

   task automatic qualify(input string name, input logic d);
      logic lq, lr, lf, lb;
      for (int k = 0; k < 13; k++) begin
         step(d);
         lq = (k >= 11) ? d : ~d;
         lr = (k == 11) && d;
         lf = (k == 11) && !d;
         lb = (k >= 2) && (k <= 10);
         chk(name, {lq, ~lq, lr, lf, lb});
      end
   endtask

   initial begin
      int   r0, f0, len;
      logic rd, lq, lr, lb;

      rst  = 1'b1;
      d_in = 1'b0;
      @(negedge clk);

      // Reset values with the input toggling.
      apply_reset(2, 1'b1);

      // Clean rise then clean fall: pulse on the 12th edge.
      d_in = 1'b0;
      qualify("clean_rise", 1'b1);
      qualify("clean_fall", 1'b0);

      // Bounce: 6 high, 2 low, then held high.
      for (int k = 0; k < 21; k++) begin
         step((k < 6 || k >= 8) ? 1'b1 : 1'b0);
         lq = (k >= 19);
         lr = (k == 19);
         lb = (k >= 2 && k <= 7) || (k >= 10 && k <= 18);
         chk("bounce", {lq, ~lq, lr, 1'b0, lb});
      end
      repeat (13) step(1'b0);
      chk("bounce_back_low", 5'b01000);

      // Reset five cycles into COUNT, then a full fresh qualification.
      for (int k = 0; k < 7; k++) step(1'b1);
      chk("mid_count_busy", 5'b01001);
      apply_reset(1, 1'b0);
      qualify("post_reset_rise", 1'b1);
      repeat (13) step(1'b0);

      // Glitches of STABLE_CNT-1 and STABLE_CNT cycles.
      r0 = n_rise; f0 = n_fall;
      repeat (SC - 1) step(1'b1);
      repeat (15) step(1'b0);
      chk_int("glitch9_rise", n_rise - r0, 0);
      chk("glitch9_q", 5'b01000);
      r0 = n_rise; f0 = n_fall;
      repeat (SC) step(1'b1);
      repeat (15) step(1'b0);
      chk_int("glitch10_rise", n_rise - r0, 1);
      chk_int("glitch10_fall", n_fall - f0, 1);

      // Vector table, each entry continuing from the previous one.
      vecs[0] = '{1'b1, 12, 1'b1, 1, 0};
      vecs[1] = '{1'b0,  5, 1'b1, 0, 0};
      vecs[2] = '{1'b1,  3, 1'b1, 0, 0};
      vecs[3] = '{1'b0, 12, 1'b0, 0, 1};
      vecs[4] = '{1'b1,  9, 1'b0, 0, 0};
      vecs[5] = '{1'b0, 14, 1'b0, 0, 0};
      vecs[6] = '{1'b1, 10, 1'b0, 0, 0};
      apply_reset(1, 1'b0);
      d_in = 1'b0;
      for (int v = 0; v < 7; v++) begin
         r0 = n_rise; f0 = n_fall;
         repeat (vecs[v].cycles) step(vecs[v].d);
         chk_int($sformatf("vec%0d_q", v), int'(q), int'(vecs[v].exp_q));
         chk_int($sformatf("vec%0d_rise", v), n_rise - r0, vecs[v].exp_rise);
         chk_int($sformatf("vec%0d_fall", v), n_fall - f0, vecs[v].exp_fall);
      end
      // The 10-cycle pulse above qualifies within the next two edges.
      r0 = n_rise;
      repeat (2) step(1'b0);
      chk_int("vec_tail_rise", n_rise - r0, 1);
      chk_int("vec_tail_q", int'(q), 1);

      // Randomized runs of random length with occasional resets.
      repeat (200) begin
         rd  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 16);
         repeat (len) step(rd);
         if ($urandom_range(0, 24) == 0) apply_reset(1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
